// File: rtl/amiga_kbd_pkg.sv
// Shared types and keycode constants for the Amiga keyboard transmitter.
package amiga_kbd_pkg;

   typedef enum logic [3:0] {
      IDLE,
      PWR0,
      PWR1,
      SETUP,
      LOW,
      HIGH,
      RELEASE,
      WAIT_HS,
      HS_END,
      RESYNC
   } kbd_state_e;

   localparam logic [7:0] KBD_CODE_LOST_SYNC = 8'hF9;
   localparam logic [7:0] KBD_CODE_INIT      = 8'hFD;
   localparam logic [7:0] KBD_CODE_TERM      = 8'hFE;

   // Reorders a keycode so that bit 7 of the result is the first bit on the wire
   function automatic logic [7:0] wire_order(input logic [7:0] code);
      return {code[6:0], code[7]};
   endfunction

endpackage

// File: rtl/amiga_kbd_phase_timer.sv
// Loadable saturating down-counter; done_c is high while the count is zero.
module amiga_kbd_phase_timer #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done_c
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_c = (cnt_q == '0);

endmodule

// File: rtl/amiga_kbd_tx.sv
// Amiga keyboard-side KCLK/KDAT transmitter with host handshake, timeout and lost-sync recovery.
// Define KBD_POWERUP_EN to send the $FD/$FE power-up frames after reset.
module amiga_kbd_tx
   import amiga_kbd_pkg::*;
#(
   parameter int unsigned BIT_PHASE_CYC = 573,
   parameter int unsigned TIMEOUT_CYC   = 4095000,
   parameter int unsigned HS_MIN_CYC    = 29
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] CODE,
   input  logic       CODE_VALID,
   output logic       CODE_READY,
   output logic       KCLK_OE,
   output logic       KDAT_OE,
   input  logic       KDAT_IN,
   output logic       SYNC_LOST
);

   localparam int unsigned PH_W  = (BIT_PHASE_CYC > 1) ? $clog2(BIT_PHASE_CYC) : 1;
   localparam int unsigned TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int unsigned RUN_W = $clog2(HS_MIN_CYC + 1);

`ifdef KBD_POWERUP_EN
   localparam kbd_state_e RESET_STATE = PWR0;
`else
   localparam kbd_state_e RESET_STATE = IDLE;
`endif

   kbd_state_e       state_q, state_d;
   logic [7:0]       hold_q, hold_d;
   logic [7:0]       sh_q, sh_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic             resync_q, resync_d;
   logic             f9_q, f9_d;
   logic             sync_lost_q, sync_lost_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic             kclk_oe_q, kclk_oe_d;
   logic             kdat_oe_q, kdat_oe_d;
   logic             code_ready_q, code_ready_d;
   logic             kdat_s1_q, kdat_s2_q;
`ifdef KBD_POWERUP_EN
   logic [1:0]       pwr_q, pwr_d;
`endif

   logic phase_load_c, phase_done_c, to_load_c, to_done_c;

   assign phase_load_c = (state_d != state_q);
   assign to_load_c    = (state_d == WAIT_HS) && (state_q != WAIT_HS);

   amiga_kbd_phase_timer #(.W(PH_W)) u_phase (
      .clk      (CLK),
      .rst      (RST),
      .load     (phase_load_c),
      .load_val (PH_W'(BIT_PHASE_CYC - 1)),
      .done_c   (phase_done_c)
   );

   amiga_kbd_phase_timer #(.W(TO_W)) u_timeout (
      .clk      (CLK),
      .rst      (RST),
      .load     (to_load_c),
      .load_val (TO_W'(TIMEOUT_CYC - 1)),
      .done_c   (to_done_c)
   );

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      sh_d        = sh_q;
      bit_cnt_d   = bit_cnt_q;
      resync_d    = resync_q;
      f9_d        = f9_q;
      sync_lost_d = sync_lost_q;
      run_d       = '0;
`ifdef KBD_POWERUP_EN
      pwr_d       = pwr_q;
`endif

      case (state_q)
         IDLE: begin
            if (CODE_VALID && code_ready_q) begin
               hold_d    = CODE;
               sh_d      = wire_order(CODE);
               bit_cnt_d = '0;
               state_d   = SETUP;
            end
         end
`ifdef KBD_POWERUP_EN
         PWR0: begin
            hold_d    = KBD_CODE_INIT;
            sh_d      = wire_order(KBD_CODE_INIT);
            bit_cnt_d = '0;
            pwr_d     = 2'd1;
            state_d   = SETUP;
         end
         PWR1: begin
            hold_d    = KBD_CODE_TERM;
            sh_d      = wire_order(KBD_CODE_TERM);
            bit_cnt_d = '0;
            pwr_d     = 2'd2;
            state_d   = SETUP;
         end
`else
         PWR0, PWR1: state_d = IDLE;
`endif
         SETUP, RESYNC: if (phase_done_c) state_d = LOW;
         LOW:           if (phase_done_c) state_d = HIGH;
         HIGH: begin
            if (phase_done_c) begin
               if (resync_q || (bit_cnt_q == 3'd7)) begin
                  state_d = RELEASE;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  sh_d      = {sh_q[6:0], 1'b0};
                  state_d   = SETUP;
               end
            end
         end
         RELEASE: begin
            if (phase_done_c) begin
               resync_d = 1'b0;
               state_d  = WAIT_HS;
            end
         end
         WAIT_HS: begin
            // Handshake qualification is checked before the timeout so it wins a tie
            if (!kdat_s2_q) begin
               run_d = (run_q == '1) ? run_q : run_q + RUN_W'(1);
            end
            if (run_d >= RUN_W'(HS_MIN_CYC)) begin
               state_d = HS_END;
            end else if (to_done_c) begin
               sync_lost_d = 1'b1;
               resync_d    = 1'b1;
               f9_d        = 1'b0;
               sh_d        = 8'hFF;
               state_d     = RESYNC;
            end
         end
         HS_END: begin
            if (kdat_s2_q) begin
               bit_cnt_d = '0;
               if (f9_q) begin
                  f9_d        = 1'b0;
                  sync_lost_d = 1'b0;
                  sh_d        = wire_order(hold_q);
                  state_d     = SETUP;
               end else if (sync_lost_q) begin
                  f9_d    = 1'b1;
                  sh_d    = wire_order(KBD_CODE_LOST_SYNC);
                  state_d = SETUP;
               end else begin
`ifdef KBD_POWERUP_EN
                  if (pwr_q == 2'd1) begin
                     state_d = PWR1;
                  end else begin
                     pwr_d   = 2'd0;
                     state_d = IDLE;
                  end
`else
                  state_d = IDLE;
`endif
               end
            end
         end
         default: state_d = IDLE;
      endcase

      kclk_oe_d    = (state_d == LOW);
      kdat_oe_d    = (state_d inside {SETUP, LOW, HIGH, RESYNC}) && sh_d[7];
      code_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= RESET_STATE;
         hold_q       <= '0;
         sh_q         <= '0;
         bit_cnt_q    <= '0;
         resync_q     <= 1'b0;
         f9_q         <= 1'b0;
         sync_lost_q  <= 1'b0;
         run_q        <= '0;
         kclk_oe_q    <= 1'b0;
         kdat_oe_q    <= 1'b0;
         code_ready_q <= 1'b0;
         kdat_s1_q    <= 1'b1;
         kdat_s2_q    <= 1'b1;
`ifdef KBD_POWERUP_EN
         pwr_q        <= 2'd0;
`endif
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         sh_q         <= sh_d;
         bit_cnt_q    <= bit_cnt_d;
         resync_q     <= resync_d;
         f9_q         <= f9_d;
         sync_lost_q  <= sync_lost_d;
         run_q        <= run_d;
         kclk_oe_q    <= kclk_oe_d;
         kdat_oe_q    <= kdat_oe_d;
         code_ready_q <= code_ready_d;
         kdat_s1_q    <= KDAT_IN;
         kdat_s2_q    <= kdat_s1_q;
`ifdef KBD_POWERUP_EN
         pwr_q        <= pwr_d;
`endif
      end
   end

   assign KCLK_OE    = kclk_oe_q;
   assign KDAT_OE    = kdat_oe_q;
   assign CODE_READY = code_ready_q;
   assign SYNC_LOST  = sync_lost_q;

endmodule

// File: tb/tb_amiga_kbd_tx.sv
// Bench for amiga_kbd_tx: a host model captures bits on KCLK rising edges and decodes frames.
`timescale 1ns/1ps
module tb_amiga_kbd_tx;

   localparam int BP = 4;
   localparam int TO = 200;
   localparam int HS = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] code = '0;
   logic       code_valid = 1'b0;
   logic       code_ready, kclk_oe, kdat_oe, sync_lost;
   logic       host_pull = 1'b0;
   logic       kdat_in;

   always #5 clk = ~clk;

   // Wired open-drain KDAT: low if either side pulls
   assign kdat_in = ~(kdat_oe | host_pull);

   amiga_kbd_tx #(.BIT_PHASE_CYC(BP), .TIMEOUT_CYC(TO), .HS_MIN_CYC(HS)) dut (
      .CLK        (clk),
      .RST        (rst),
      .CODE       (code),
      .CODE_VALID (code_valid),
      .CODE_READY (code_ready),
      .KCLK_OE    (kclk_oe),
      .KDAT_OE    (kdat_oe),
      .KDAT_IN    (kdat_in),
      .SYNC_LOST  (sync_lost)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Host sampler: KCLK rises when KCLK_OE drops
   logic kclk_prev = 1'b0;
   bit   bit_q[$];
   int   rise_q[$];
   always @(negedge clk) begin
      if (kclk_prev && !kclk_oe) begin
         bit_q.push_back(kdat_oe);
         rise_q.push_back(cyc);
      end
      kclk_prev = kclk_oe;
   end

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Wire order is code[6..0] then code[7]; first wire bit lands in w[7]
   function automatic logic [7:0] decode(input logic [7:0] w);
      logic [7:0] c;
      for (int i = 0; i < 7; i++) c[6-i] = w[7-i];
      c[7] = w[0];
      return c;
   endfunction

   task automatic get_bits(input int n, input string tag, output logic [7:0] w, output int rise);
      int budget;
      budget = 3000;
      w = '0;
      rise = 0;
      while (bit_q.size() < n && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (bit_q.size() < n) begin
         chk({tag, "_timeout"}, 32'(bit_q.size()), 32'(n));
         return;
      end
      for (int i = 0; i < n; i++) begin
         w = {w[6:0], bit_q.pop_front()};
         rise = rise_q.pop_front();
      end
   endtask

   task automatic send(input logic [7:0] c);
      int budget;
      budget = 500;
      code = c;
      code_valid = 1'b1;
      while (!code_ready && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (!code_ready) chk("send_timeout", 32'(code_ready), 32'd1);
      @(posedge clk);
      #1 code_valid = 1'b0;
   endtask

   // Host handshake: pull KDAT low for len cycles once the keyboard is waiting
   task automatic host_hs(input int rise, input int len, output int n_ready);
      int budget;
      budget = 100;
      n_ready = 0;
      while (cyc < rise + 2*BP + 3 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      host_pull = 1'b1;
      repeat (len) begin
         @(negedge clk);
         if (code_ready) n_ready++;
      end
      host_pull = 1'b0;
   endtask

   task automatic wait_ready(input string tag);
      int budget;
      budget = 50;
      while (!code_ready && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      chk(tag, 32'(code_ready), 32'd1);
   endtask

   task automatic frame_hs(input logic [7:0] exp, input string tag);
      logic [7:0] w;
      int r, n;
      get_bits(8, tag, w, r);
      chk(tag, 32'(decode(w)), 32'(exp));
      host_hs(r, 3 + int'($urandom_range(0, 9)), n);
   endtask

   task automatic powerup_seq();
`ifdef KBD_POWERUP_EN
      frame_hs(8'hFD, "pwr_fd");
      chk("pwr_ready_low", 32'(code_ready), 32'd0);
      frame_hs(8'hFE, "pwr_fe");
      wait_ready("pwr_ready");
`endif
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] w, c;
      int r, r_prev, t0, n;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_kclk_oe", 32'(kclk_oe), 32'd0);
      chk("rst_kdat_oe", 32'(kdat_oe), 32'd0);
      chk("rst_ready", 32'(code_ready), 32'd0);
      chk("rst_sync_lost", 32'(sync_lost), 32'd0);
      rst = 1'b0;
      @(negedge clk);
`ifdef KBD_POWERUP_EN
      chk("ready_in_powerup", 32'(code_ready), 32'd0);
`else
      chk("ready_after_rst", 32'(code_ready), 32'd1);
`endif
      powerup_seq();

      // Directed $45 frame with a 10-cycle handshake
      send(8'h45);
      get_bits(8, "f45", w, r);
      chk("f45_wire", 32'(w), 32'b1000_1010);
      chk("f45_code", 32'(decode(w)), 32'h45);
      host_hs(r, 10, n);
      chk("f45_ready_during_hs", 32'(n), 32'd0);
      wait_ready("f45_ready");
      chk("f45_sync_lost", 32'(sync_lost), 32'd0);

      // No handshake: timeout, resync bits, then $F9 and retransmission
      send(8'h45);
      get_bits(8, "to_f45", w, r);
      chk("to_f45", 32'(decode(w)), 32'h45);
      t0 = -1;
      for (int k = 0; k < 400 && t0 < 0; k++) begin
         @(negedge clk);
         if (sync_lost) t0 = cyc;
      end
      chk("to_sync_lost_at", 32'(t0 - r), 32'(2*BP + TO));
      r_prev = r;
      for (int i = 0; i < 3; i++) begin
         get_bits(1, "rs", w, r);
         chk("rs_bit", 32'(w[0]), 32'd1);
         chk("rs_spacing", 32'(r - r_prev), 32'(4*BP + TO));
         r_prev = r;
      end
      chk("rs_sync_lost", 32'(sync_lost), 32'd1);
      host_hs(r, 6, n);
      get_bits(8, "rs_f9", w, r);
      chk("rs_f9", 32'(decode(w)), 32'hF9);
      chk("rs_f9_sync_lost", 32'(sync_lost), 32'd1);
      host_hs(r, 6, n);
      get_bits(8, "rs_resend", w, r);
      chk("rs_resend", 32'(decode(w)), 32'h45);
      chk("rs_resend_sync_lost", 32'(sync_lost), 32'd0);
      host_hs(r, 6, n);
      wait_ready("rs_ready");

      // One-cycle glitches during the wait must not count as a handshake
      c = 8'($urandom);
      send(c);
      get_bits(8, "gl", w, r);
      chk("gl_frame", 32'(decode(w)), 32'(c));
      t0 = -1;
      for (int k = 0; k < 400 && t0 < 0; k++) begin
         @(negedge clk);
         host_pull = ((cyc - r) >= 13) && ((cyc - r) < 2*BP + TO - 10) && (((cyc - r) % 15) == 0);
         if (sync_lost) t0 = cyc;
      end
      host_pull = 1'b0;
      chk("gl_timeout_at", 32'(t0 - r), 32'(2*BP + TO));
      get_bits(1, "gl_rs", w, r);
      chk("gl_rs_bit", 32'(w[0]), 32'd1);
      host_hs(r, 5, n);
      frame_hs(8'hF9, "gl_f9");
      frame_hs(c, "gl_resend");
      wait_ready("gl_ready");
      chk("gl_sync_lost", 32'(sync_lost), 32'd0);

      // Random codes with random handshake lengths
      for (int i = 0; i < 4; i++) begin
         c = 8'($urandom);
         repeat ($urandom_range(0, 5)) @(negedge clk);
         send(c);
         frame_hs(c, "rnd_frame");
         wait_ready("rnd_ready");
      end

      // Async reset while KCLK is pulled low during bit 4 (code bit 3 forced to 1)
      c = 8'($urandom) | 8'h08;
      send(c);
      t0 = 3000;
      while (bit_q.size() < 3 && t0 > 0) begin @(negedge clk); t0--; end
      while (!kclk_oe && t0 > 0) begin @(negedge clk); t0--; end
      chk("pre_rst_kclk", 32'(kclk_oe), 32'd1);
      chk("pre_rst_kdat", 32'(kdat_oe), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_kclk", 32'(kclk_oe), 32'd0);
      chk("rst_mid_kdat", 32'(kdat_oe), 32'd0);
      repeat (2) @(negedge clk);
      bit_q.delete();
      rise_q.delete();
      chk("rst_mid_ready", 32'(code_ready), 32'd0);
      rst = 1'b0;
      @(negedge clk);
`ifdef KBD_POWERUP_EN
      chk("rst_mid_ready_pwr", 32'(code_ready), 32'd0);
`else
      chk("rst_mid_idle", 32'(code_ready), 32'd1);
`endif
      powerup_seq();

      // CODE_VALID held while the host keeps KDAT low well past qualification
      c = 8'($urandom);
      send(c);
      get_bits(8, "hold", w, r);
      chk("hold_frame", 32'(decode(w)), 32'(c));
      code = 8'h12;
      code_valid = 1'b1;
      host_hs(r, 26, n);
      chk("hold_ready_low", 32'(n), 32'd0);
      chk("hold_no_tx", 32'(bit_q.size()), 32'd0);
      send(8'h12);
      frame_hs(8'h12, "hold_f12");
      wait_ready("hold_ready");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
